// File: rtl/condicionador_entradas.sv
// Input conditioning ahead of the sequence game FSM: every raw key/switch is
// synchronized and debounced per channel, then turned into clean levels and
// single-cycle rising-edge pulses. All outputs derive from registered state.

// One debounce channel: 2-FF synchronizer, agreement-reset counter, stable
// level and its one-cycle-delayed copy for edge detection.
module condicionador_canal #(
    parameter int DEBOUNCE_CICLOS = 50000,
    parameter int LARG_CONT       = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic bruto,
    output logic est,
    output logic est_ant,
    output logic cnt_zero
);
    localparam logic [LARG_CONT-1:0] CNT_MAX = LARG_CONT'(DEBOUNCE_CICLOS - 1);

    logic                 s1;
    logic                 s2;
    logic [LARG_CONT-1:0] cnt;

    // Two-flop synchronizer for the asynchronous raw input
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= bruto;
            s2 <= s1;
        end
    end

    // Accept a new level only after DEBOUNCE_CICLOS consecutive disagreeing
    // samples; any single agreeing sample throws the partial count away.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            est     <= 1'b0;
            est_ant <= 1'b0;
        end else begin
            est_ant <= est;
            if (s2 == est) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                est <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + LARG_CONT'(1);
            end
        end
    end

    assign cnt_zero = (cnt == '0);
endmodule

// Six independent channels: buttons 0..3, jogar (4), modo (5).
module condicionador_entradas #(
    parameter int DEBOUNCE_CICLOS = 50000,
    parameter int LARG_CONT       = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] botoes_brutos,
    input  logic       jogar_bruto,
    input  logic       modo_bruto,
    output logic [3:0] botoes,
    output logic [3:0] botoes_pulso,
    output logic       jogar_pulso,
    output logic       modo,
    output logic       multiplo,
    output logic       db_estavel
);
    localparam int NUM_CANAIS = 6;
    localparam int CH_JOGAR   = 4;
    localparam int CH_MODO    = 5;

    logic [NUM_CANAIS-1:0] bruto;
    logic [NUM_CANAIS-1:0] est;
    logic [NUM_CANAIS-1:0] est_ant;
    logic [NUM_CANAIS-1:0] cnt_zero;
    logic [2:0]            qtd_botoes;

    assign bruto = {modo_bruto, jogar_bruto, botoes_brutos};

    for (genvar g = 0; g < NUM_CANAIS; g++) begin : g_canal
        condicionador_canal #(
            .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS),
            .LARG_CONT      (LARG_CONT)
        ) u_canal (
            .clock   (clock),
            .reset   (reset),
            .bruto   (bruto[g]),
            .est     (est[g]),
            .est_ant (est_ant[g]),
            .cnt_zero(cnt_zero[g])
        );
    end

    // Number of buttons currently held (stable level)
    always_comb begin
        qtd_botoes = '0;
        for (int i = 0; i < 4; i++) begin
            qtd_botoes = qtd_botoes + {2'b00, est[i]};
        end
    end

    // A button pulse is only meaningful when it is the sole button held, so
    // chords and presses during another held button never pulse.
    assign botoes       = est[3:0];
    assign botoes_pulso = est[3:0] & ~est_ant[3:0] & {4{qtd_botoes == 3'd1}};
    assign jogar_pulso  = est[CH_JOGAR] & ~est_ant[CH_JOGAR];
    assign modo         = est[CH_MODO];
    assign multiplo     = (qtd_botoes >= 3'd2);
    assign db_estavel   = &cnt_zero;
endmodule

// File: tb/tb_condicionador_entradas.sv
// Directed bench for condicionador_entradas (DEBOUNCE_CICLOS=4, 20 ns clock).
// A window-based behavioural model predicts every output each cycle; literal
// expectations pin the timing scenarios by hand.
module tb_condicionador_entradas;
    localparam int D = 4;

    logic       clock;
    logic       reset;
    logic [3:0] botoes_brutos;
    logic       jogar_bruto;
    logic       modo_bruto;
    logic [3:0] botoes;
    logic [3:0] botoes_pulso;
    logic       jogar_pulso;
    logic       modo;
    logic       multiplo;
    logic       db_estavel;

    int n_chk;
    int n_fail;

    condicionador_entradas #(.DEBOUNCE_CICLOS(D), .LARG_CONT(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .botoes_brutos(botoes_brutos),
        .jogar_bruto  (jogar_bruto),
        .modo_bruto   (modo_bruto),
        .botoes       (botoes),
        .botoes_pulso (botoes_pulso),
        .jogar_pulso  (jogar_pulso),
        .modo         (modo),
        .multiplo     (multiplo),
        .db_estavel   (db_estavel)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    // ---------------- behavioural model ----------------
    // A channel accepts the opposite level once the last D synchronized
    // samples all disagree with it and at least D samples were taken since
    // its previous change (or reset).
    logic [5:0]   m_s1, m_s2, m_last, m_est, m_ant;
    logic [D-1:0] m_hist [6];
    int           m_since [6];

    function automatic logic aceita(input logic [D-1:0] h, input logic s,
                                    input int since, input logic e);
        logic [D-1:0] janela;
        janela = {h[D-2:0], s};
        return (since + 1 >= D) && (janela == {D{~e}});
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_s1   <= '0;
            m_s2   <= '0;
            m_last <= '0;
            m_est  <= '0;
            m_ant  <= '0;
            for (int ch = 0; ch < 6; ch++) begin
                m_hist[ch]  <= '0;
                m_since[ch] <= 0;
            end
        end else begin
            m_s1   <= {modo_bruto, jogar_bruto, botoes_brutos};
            m_s2   <= m_s1;
            m_last <= m_s2;
            m_ant  <= m_est;
            for (int ch = 0; ch < 6; ch++) begin
                m_hist[ch] <= {m_hist[ch][D-2:0], m_s2[ch]};
                if (aceita(m_hist[ch], m_s2[ch], m_since[ch], m_est[ch])) begin
                    m_est[ch]   <= ~m_est[ch];
                    m_since[ch] <= 0;
                end else begin
                    m_since[ch] <= (m_since[ch] + 1 >= D) ? D : m_since[ch] + 1;
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string nome, input logic [11:0] got, input logic [11:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nome, got, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [3:0] eb, ep;
        int         pc;
        logic [11:0] esperado;
        eb = m_est[3:0];
        pc = $countones(eb);
        ep = (pc == 1) ? (eb & ~m_ant[3:0]) : 4'b0000;
        esperado = {eb, ep, m_est[4] & ~m_ant[4], m_est[5], pc >= 2, m_last == m_est};
        chk("modelo", {botoes, botoes_pulso, jogar_pulso, modo, multiplo, db_estavel}, esperado);
    endtask

    task automatic tick();
        @(negedge clock);
        check_model();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [11:0] saidas();
        return {botoes, botoes_pulso, jogar_pulso, modo, multiplo, db_estavel};
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [5:0] pat;
        n_chk  = 0;
        n_fail = 0;
        reset  = 1'b1;
        botoes_brutos = 4'($urandom);
        jogar_bruto   = 1'($urandom);
        modo_bruto    = 1'($urandom);
        #1 reset = 1'b0;
        #1 chk("reset saidas", saidas(), 12'h001);

        // 1. reset with random inputs, then release with inputs low
        for (int i = 0; i < 3; i++) begin
            tick();
            botoes_brutos = 4'($urandom);
            jogar_bruto   = 1'($urandom);
            modo_bruto    = 1'($urandom);
        end
        chk("reset ciclos", saidas(), 12'h001);
        botoes_brutos = 4'b0000;
        jogar_bruto   = 1'b0;
        modo_bruto    = 1'b0;
        reset         = 1'b1;
        ticks(6);
        chk("pos reset", saidas(), 12'h001);

        // 2. clean press of button 2
        botoes_brutos = 4'b0100;
        ticks(2);
        chk("t2 db antes contagem", {11'h0, db_estavel}, 12'h001);
        tick();
        chk("t2 db contando", {11'h0, db_estavel}, 12'h000);
        ticks(2);
        chk("t2 botoes t0+4", {8'h0, botoes}, 12'h000);
        tick();
        chk("t2 botoes t0+5", {8'h0, botoes}, 12'h004);
        chk("t2 pulso", {8'h0, botoes_pulso}, 12'h004);
        tick();
        chk("t2 pulso unico", {8'h0, botoes_pulso}, 12'h000);
        ticks(3);
        botoes_brutos = 4'b0000;
        ticks(5);
        chk("t2 soltar t0+4", {8'h0, botoes}, 12'h004);
        tick();
        chk("t2 soltar t0+5", {8'h0, botoes}, 12'h000);
        chk("t2 sem pulso soltar", {8'h0, botoes_pulso}, 12'h000);
        ticks(3);

        // 3. bounce on jogar: 1,0,1,1,0,1 then held
        pat = 6'b101101;
        for (int i = 0; i < 6; i++) begin
            jogar_bruto = pat[5-i];
            tick();
            if (i == 2) chk("t3 db bounce", {11'h0, db_estavel}, 12'h000);
        end
        ticks(4);
        chk("t3 sem pulso cedo", {11'h0, jogar_pulso}, 12'h000);
        tick();
        chk("t3 pulso", {11'h0, jogar_pulso}, 12'h001);
        tick();
        chk("t3 pulso fim", {11'h0, jogar_pulso}, 12'h000);
        ticks(2);
        jogar_bruto = 1'b0;
        ticks(8);

        // 4. multiple buttons
        botoes_brutos = 4'b0001;
        ticks(6);
        chk("t4 pulso b0", {8'h0, botoes_pulso}, 12'h001);
        ticks(2);
        botoes_brutos = 4'b0011;
        ticks(6);
        chk("t4 botoes 0011", {8'h0, botoes}, 12'h003);
        chk("t4 multiplo", {11'h0, multiplo}, 12'h001);
        chk("t4 sem pulso b1", {8'h0, botoes_pulso}, 12'h000);
        botoes_brutos = 4'b0000;
        ticks(8);
        botoes_brutos = 4'b1100;
        ticks(6);
        chk("t4 botoes 1100", {8'h0, botoes}, 12'h00c);
        chk("t4 sem pulso simult", {8'h0, botoes_pulso}, 12'h000);
        botoes_brutos = 4'b0000;
        ticks(8);

        // 5. glitch rejection on modo
        modo_bruto = 1'b1;
        ticks(3);
        modo_bruto = 1'b0;
        ticks(8);
        chk("t5 glitch rejeitado", {11'h0, modo}, 12'h000);
        modo_bruto = 1'b1;
        ticks(6);
        chk("t5 modo aceito", {11'h0, modo}, 12'h001);
        ticks(2);
        modo_bruto = 1'b0;
        ticks(8);
        chk("t5 modo solto", {11'h0, modo}, 12'h000);

        // 6. reset during a count
        botoes_brutos = 4'b0001;
        ticks(3);
        chk("t6 contando", {11'h0, db_estavel}, 12'h000);
        reset = 1'b0;
        #1 chk("t6 reset assincrono", saidas(), 12'h001);
        ticks(2);
        reset = 1'b1;
        ticks(5);
        chk("t6 sem pulso cedo", {8'h0, botoes_pulso}, 12'h000);
        tick();
        chk("t6 pulso pos reset", {8'h0, botoes_pulso}, 12'h001);
        tick();
        chk("t6 pulso unico", {8'h0, botoes_pulso}, 12'h000);
        botoes_brutos = 4'b0000;
        ticks(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/condicionador_entradas.md
# condicionador_entradas

Input-conditioning stage placed directly upstream of `circuito_jogo_sequencias`. It takes the raw, asynchronous board switches and keys (four game buttons, `jogar`, `modo`) and synchronizes and debounces each one. It delivers clean stable levels and single-cycle rising-edge pulses, so the game FSM never sees bounce, metastability or multi-button garbage. All outputs come from registered state in the `clock` domain.

## Interface

Parameters:
- `DEBOUNCE_CICLOS`, default 50000: consecutive cycles an input must hold a new value before it is accepted (1 ms at 50 MHz). Legal range is ≥ 2.
- `LARG_CONT`, default 16: debounce counter width. Must satisfy 2^LARG_CONT > DEBOUNCE_CICLOS−1.

Ports:
- `clock`  in  1: system clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset. 0 clears all state immediately.
- `botoes_brutos`  in  4: raw game buttons, active-high, asynchronous.
- `jogar_bruto`  in  1: raw start key, active-high, asynchronous.
- `modo_bruto`  in  1: raw mode switch, asynchronous.
- `botoes`  out  4: debounced button levels.
- `botoes_pulso`  out  4: one-cycle pulse per accepted single-button press.
- `jogar_pulso`  out  1: one-cycle pulse on debounced rising edge of jogar.
- `modo`  out  1: debounced mode level.
- `multiplo`  out  1: high while more than one debounced button is high.
- `db_estavel`  out  1: high when no channel has a nonzero debounce counter.

## Operation

- Six identical channels: `botoes_brutos[3:0]`, `jogar_bruto`, `modo_bruto`.
- Each channel contains:
  - a 2-FF synchronizer (`s1` → `s2`);
  - a debounce counter `cnt`;
  - a stable register `est`;
  - a previous-stable register `est_ant`.
- Per channel, every rising clock edge:
  - If `s2 == est`: `cnt <= 0`.
  - Else, if `cnt == DEBOUNCE_CICLOS−1`: `est <= s2`, `cnt <= 0`.
  - Else: `cnt <= cnt + 1`.
  - In all cases, `est_ant <= est`.
- Any single cycle of agreement (a bounce back) restarts the count from 0. Partial counts are never retained.
- The counter never exceeds DEBOUNCE_CICLOS−1, so there is no wrap-around.
- `botoes = est[3:0]`, `modo = est_modo`.
- `jogar_pulso = est_jogar & ~est_ant_jogar`.
- `botoes_pulso[i] = est[i] & ~est_ant[i] & (popcount(est[3:0]) == 1)`.
  - A rising edge that coincides with, or occurs while, another button is stably pressed is suppressed, and no pulse is emitted later.
  - If two buttons become stable on the same edge, no pulse is emitted.
- `multiplo = popcount(est[3:0]) ≥ 2`.
- Falling edges never produce pulses.
- `db_estavel` is the NOR of all six counters being nonzero (high when every counter is 0).

Reset (`reset` = 0, asynchronous):
- All of `s1`, `s2`, `cnt`, `est`, `est_ant` clear to 0.
- Output values during and after reset: `botoes`=0000, `botoes_pulso`=0000, `jogar_pulso`=0, `modo`=0, `multiplo`=0, `db_estavel`=1.
- An input held high through reset release is accepted normally after the debounce time. Because `est_ant` is 0, this produces one rising-edge pulse. That is required behaviour: a key held at reset counts as one press.
- Reset asserted mid-count discards the count. No pulse is emitted.

## Timing

- Raw input changes and is then held constant. Let t0 be the first edge that samples the new value into `s1`.
  - `s2` updates at t0+1.
  - `est` updates at edge t0+1+DEBOUNCE_CICLOS.
  - The pulse is high for exactly the one cycle between edges t0+1+DEBOUNCE_CICLOS and t0+2+DEBOUNCE_CICLOS.
- A glitch must not be accepted: a pulse held for ≤ DEBOUNCE_CICLOS−1 cycles after synchronization never changes `est`.
- Pulse width is always exactly 1 cycle. Pulse spacing is ≥ 2·DEBOUNCE_CICLOS cycles per channel (release + re-press).
- There is no combinational path from any input to any output.
- Channels are fully independent. Simultaneous events on different channels are processed in parallel with no priority.

## Test plan

All scenarios use DEBOUNCE_CICLOS=4 and clock period 20 ns.

1. Reset value check: apply `reset`=0 with random inputs. Required: all outputs 0 except `db_estavel`=1. Release `reset`: outputs remain at those values for at least 5 cycles with inputs at 0.
2. Clean press of `botoes_brutos`=0100, held 10 cycles:
   - `botoes`=0100 exactly 5 edges after the first sampling edge;
   - `botoes_pulso`=0100 for exactly 1 cycle;
   - no pulse on release; `botoes` returns to 0000 five edges after release.
3. Bounce on `jogar_bruto` of 1,0,1,1,0,1 (one cycle each), then held high:
   - `est` changes only after 4 consecutive synchronized 1s;
   - a single `jogar_pulso`;
   - `db_estavel`=0 during the bounce.
4. Multiple buttons:
   - Press 0001 and keep it stable, then press 0010: `botoes`=0011, `multiplo`=1, no `botoes_pulso[1]`.
   - Press 1000 and 0100 on the same cycle: `botoes`=1100 with no pulse.
5. Glitch rejection: `modo_bruto` high for 3 cycles → `modo` stays 0. Then high for 8 cycles → `modo`=1, and no pulse output exists for `modo`.
6. Mid-count reset: press button 0 and assert `reset`=0 two cycles later. All outputs clear asynchronously. After release, with the button still held, exactly one `botoes_pulso`=0001 occurs 5 edges after the first post-reset sampling edge.
